// File: rtl/store_buffer_pkg.sv
// Shared constants for the store buffer: store size encodings and byte-enable width.
package store_buffer_pkg;

  localparam int unsigned BE_W = 4;

  // Encoding of {sb, sh}; 2'b11 falls through to word handling.
  typedef enum logic [1:0] {
    SZ_W = 2'b00,
    SZ_H = 2'b01,
    SZ_B = 2'b10
  } size_e;

endpackage

// File: rtl/store_lane_align.sv
// Places low-aligned store data into its byte lanes and flags illegal alignment.
module store_lane_align
  import store_buffer_pkg::*;
(
  input  logic            sb,
  input  logic            sh,
  input  logic [1:0]      off,
  input  logic [31:0]     st_data,
  output logic [31:0]     wdata,
  output logic [BE_W-1:0] be,
  output logic            illegal
);

  always_comb begin
    wdata   = '0;
    be      = '0;
    illegal = 1'b0;
    case ({sb, sh})
      SZ_B: begin
        be    = 4'b0001 << off;
        wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        if (off == 2'd3) begin
          illegal = 1'b1;
        end else begin
          be    = 4'b0011 << off;
          wdata = {16'h0000, st_data[15:0]} << {off, 3'b000};
        end
      end
      default: begin
        if (off != 2'd0) begin
          illegal = 1'b1;
        end else begin
          be    = '1;
          wdata = st_data;
        end
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Store queue between the MEM stage and the data memory write port, with a
// conservative word-address hazard check for younger loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic                     sb,
  input  logic                     sh,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     misalign,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hazard,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  output logic [BE_W-1:0]          mem_be,
  input  logic                     mem_ack,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-3:0]   addr_q  [DEPTH];
  logic [DW-1:0]   data_q  [DEPTH];
  logic [BE_W-1:0] be_q    [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic            misalign_q;

  logic [DW-1:0]   al_wdata;
  logic [BE_W-1:0] al_be;
  logic            al_illegal;
  logic            full, push, pop;
  logic            unused_ld_off;

  store_lane_align u_align (
    .sb      (sb),
    .sh      (sh),
    .off     (st_addr[1:0]),
    .st_data (st_data),
    .wdata   (al_wdata),
    .be      (al_be),
    .illegal (al_illegal)
  );

  // Readiness comes from registered occupancy only, so a same-cycle pop never frees a slot.
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign st_ready = !full;
  assign push     = st_valid && !full && !al_illegal;
  assign pop      = mem_ack && !empty;

  assign mem_req   = !empty;
  assign mem_addr  = {addr_q[rd_ptr], 2'b00};
  assign mem_wdata = data_q[rd_ptr];
  assign mem_be    = be_q[rd_ptr];
  assign count     = count_q;
  assign misalign  = misalign_q;
  assign unused_ld_off = ^ld_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= st_valid && !full && al_illegal;
      if (push) begin
        wr_ptr          <= wr_ptr + 1'b1;
        valid_q[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        valid_q[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= st_addr[AW-1:2];
      data_q[wr_ptr] <= al_wdata;
      be_q[wr_ptr]   <= al_be;
    end
  end

  always_comb begin
    ld_hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == ld_addr[AW-1:2])) ld_hazard = ld_valid;
    end
  end

endmodule
